pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Parametrised successor to the single-cycle next-PC logic.
- Holds the architectural PC register and resolves conditional (B) and register (BR) branches for the instruction in decode.
- Issues a one-cycle flush on redirect and implements a sticky HALT state.
- Keeps saturating branch performance counters.
- Sits between the fetch stage (drives imem address) and the decode stage (supplies the decoded instruction, its PC, flags and rs data).

Parameters:
ADDR_W, 16, PC/address width in bits
INSTR_W, 16, instruction width; opcode is the top 4 bits
OFF_W, 9, branch immediate field width, taken from instr[OFF_W-1:0]
SIGNED_OFF, 1, 1 = sign-extend the offset, 0 = zero-extend it
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard stall; freezes PC, state and counters
dec_valid  in  1  dec_instr/dec_pc hold a live instruction
dec_instr  in  INSTR_W  instruction in decode
dec_pc  in  ADDR_W  PC of the instruction in decode
flags  in  3  {V,N,Z}: flags[0]=Z, flags[1]=N, flags[2]=V
rs_data  in  ADDR_W  BR target (register value)
pc  out  ADDR_W  registered fetch address
flush  out  1  combinational; kill the fetched (younger) instruction this cycle
halted  out  1  registered, sticky
br_cnt  out  CNT_W  resolved B/BR count, saturating
taken_cnt  out  CNT_W  taken B/BR count, saturating

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=RUN, halted=0, br_cnt=0, taken_cnt=0. flush=0 while in reset.
- Opcodes: 4'hC = B, 4'hD = BR, 4'hF = HLT. All other opcodes are non-control.
- Condition field is instr[11:9]:
  - 000: ~Z
  - 001: Z
  - 010: ~Z&~N
  - 011: N
  - 100: Z|~N
  - 101: Z|N
  - 110: V
  - 111: always
- B target = dec_pc + 2 + (ext(imm) << 1), computed modulo 2^ADDR_W. Wrap-around is legal and silent.
- BR target = rs_data with bit 0 forced to 0.
- taken = dec_valid & (B|BR) & cond.
- States: RUN, HALTED.
- RUN, stall=0, evaluated in priority order:
  - dec_valid & HLT: pc <= dec_pc, flush=1, halted <= 1, go to HALTED.
  - else if taken: pc <= target, flush=1.
  - else: pc <= pc + 2, flush=0.
- RUN, stall=1: pc, state and counters hold; flush=0. The branch is re-evaluated when stall drops, because decode holds the instruction.
- HALTED: pc, counters and flush (0) hold regardless of inputs. Only reset exits HALTED.
- Counters, updated in RUN with stall=0:
  - br_cnt increments on dec_valid & (B|BR), regardless of cond.
  - taken_cnt increments on taken.
  - Both saturate at all-ones; no wrap.
- dec_valid=0: no redirect, no count; pc advances by 2 unless stalled.
- Reset asserted mid-stall or mid-redirect: reset wins immediately and asynchronously.
- Redirect latency: the target appears on pc one clock after the decode cycle. Exactly one instruction is flushed.

Decomposition:
- Package pc_ctrl_pkg holds:
  - opcode constants OP_B, OP_BR, OP_HLT
  - cond_e enum (NEQ, EQ, GT, LT, GTE, LTE, OVF, UNCOND)
  - state_e {RUN, HALTED}
  - flag bit index constants
- One sub-module, branch_cond_eval: purely combinational; inputs cond and flags, output pass.
- Adders are inferred; rca_16bit is not used, since widths are parametric.

Test Plan:
- Reset with RESET_PC=16'h0100, then 3 clocks of dec_valid=0 and stall=0 -> pc goes 0100, 0102, 0104, 0106; flush=0; counters=0.
- B cond=001 (EQ), Z=1, dec_pc=16'h0010, imm=9'h1FE, SIGNED_OFF=1 -> flush=1 for one cycle; next pc=0x000E; br_cnt=1, taken_cnt=1. The same case with Z=0 -> pc=prev+2; br_cnt=1, taken_cnt=0.
- BR cond=111, rs_data=16'h4321 -> pc=16'h4320 next cycle; flush=1 for one cycle.
- Wrap and stall:
  - B at dec_pc=16'hFFFC, imm=+3 -> pc=16'h0004 (wraps).
  - A taken branch held under stall for 2 cycles -> pc frozen and flush=0 during the stall; redirect fires in the cycle stall drops.
- HLT at dec_pc=16'h0040 -> pc=0x0040 and halted=1 next cycle. Subsequent taken branches with stall toggling -> no change. Asserting rst_n low mid-run -> immediate return to RESET_PC with halted=0.
- CNT_W=2 with 5 taken branches -> br_cnt=taken_cnt=3 (saturated).

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared opcodes, condition codes, FSM states and flag positions for the
// PC / fetch controller.
package pc_ctrl_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [2:0] {
        NEQ    = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVF    = 3'b110,
        UNCOND = 3'b111
    } cond_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_B) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a 3-bit branch condition against {V,N,Z}.
module branch_cond_eval
    import pc_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       pass
);

    logic z_s;
    logic n_s;
    logic v_s;

    assign z_s = flags[FLAG_Z];
    assign n_s = flags[FLAG_N];
    assign v_s = flags[FLAG_V];

    // Condition code decode
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            NEQ:     pass = ~z_s;
            EQ:      pass = z_s;
            GT:      pass = ~z_s & ~n_s;
            LT:      pass = n_s;
            GTE:     pass = z_s | ~n_s;
            LTE:     pass = z_s | n_s;
            OVF:     pass = v_s;
            UNCOND:  pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC register with B/BR branch resolution, one-cycle flush on
// redirect, sticky HALT and saturating branch performance counters.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int INSTR_W    = 16,
    parameter int OFF_W      = 9,
    parameter int SIGNED_OFF = 1,
    parameter int RESET_PC   = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               dec_valid,
    input  logic [INSTR_W-1:0] dec_instr,
    input  logic [ADDR_W-1:0]  dec_pc,
    input  logic [2:0]         flags,
    input  logic [ADDR_W-1:0]  rs_data,
    output logic [ADDR_W-1:0]  pc,
    output logic               flush,
    output logic               halted,
    output logic [CNT_W-1:0]   br_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd2);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] BR_MASK  = ~ADDR_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
    logic               flush_s;

    logic [3:0]         opcode_s;
    logic [2:0]         cond_s;
    logic [OFF_W-1:0]   imm_s;
    logic [ADDR_W-1:0]  off_ext_s;
    logic [ADDR_W-1:0]  b_target_s;
    logic [ADDR_W-1:0]  br_target_s;
    logic [ADDR_W-1:0]  target_s;
    logic               cond_pass_s;
    logic               is_ctrl_s;
    logic               is_hlt_s;
    logic               taken_s;

    assign opcode_s = dec_instr[INSTR_W-1 -: 4];
    assign cond_s   = dec_instr[11:9];
    assign imm_s    = dec_instr[OFF_W-1:0];

    branch_cond_eval u_cond (
        .cond  (cond_s),
        .flags (flags),
        .pass  (cond_pass_s)
    );

    // Offset extension selected by the SIGNED_OFF parameter
    always_comb begin
        if (SIGNED_OFF != 0) begin
            off_ext_s = ADDR_W'($signed(imm_s));
        end else begin
            off_ext_s = ADDR_W'(imm_s);
        end
    end

    assign b_target_s  = dec_pc + PC_STEP + (off_ext_s << 1);
    assign br_target_s = rs_data & BR_MASK;
    assign target_s    = (opcode_s == OP_BR) ? br_target_s : b_target_s;
    assign is_ctrl_s   = dec_valid & is_branch_op(opcode_s);
    assign is_hlt_s    = dec_valid & (opcode_s == OP_HLT);
    assign taken_s     = is_ctrl_s & cond_pass_s;

    // Next-state, next-PC, counter and flush logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        flush_s     = 1'b0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    // HLT outranks any branch: it parks pc on its own address
                    if (is_hlt_s) begin
                        pc_d    = dec_pc;
                        flush_s = 1'b1;
                        state_d = HALTED;
                    end else if (taken_s) begin
                        pc_d    = target_s;
                        flush_s = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                    if (is_ctrl_s && (br_cnt_q != '1)) begin
                        br_cnt_d = br_cnt_q + CNT_ONE;
                    end else begin
                        br_cnt_d = br_cnt_q;
                    end
                    if (taken_s && (taken_cnt_q != '1)) begin
                        taken_cnt_d = taken_cnt_q + CNT_ONE;
                    end else begin
                        taken_cnt_d = taken_cnt_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // State, PC and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= PC_RESET;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_s & rst_n;
    assign halted    = (state_q == HALTED);
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, corner sequences and random
// stimulus against a behavioural model; two instances (signed/16-bit counters
// and zero-extended/2-bit counters) share the same stimulus.
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        v;
        logic [15:0] instr;
        logic [15:0] dpc;
        logic [2:0]  fl;
        logic [15:0] rs;
        logic        st;
        logic        ef;
        logic [15:0] epc;
        logic        eh;
        logic [15:0] ebr;
        logic [15:0] etk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [2:0]  flags;
    logic [15:0] rs_data;

    logic [15:0] pc0, pc1;
    logic        flush0, flush1, halted0, halted1;
    logic [15:0] br0, tk0;
    logic [1:0]  br1, tk1;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] m_pc [2];
    bit          m_halt;
    int          m_br, m_tk;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .OFF_W(9), .SIGNED_OFF(1),
                    .RESET_PC('h0100), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .flags(flags), .rs_data(rs_data),
        .pc(pc0), .flush(flush0), .halted(halted0), .br_cnt(br0), .taken_cnt(tk0));

    pc_fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .OFF_W(9), .SIGNED_OFF(0),
                    .RESET_PC('h0100), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .flags(flags), .rs_data(rs_data),
        .pc(pc1), .flush(flush1), .halted(halted1), .br_cnt(br1), .taken_cnt(tk1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
        bit z, n, v;
        z = f[0]; n = f[1]; v = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_isbr();
        return dec_valid && (dec_instr[15:12] == 4'hC || dec_instr[15:12] == 4'hD);
    endfunction

    function automatic bit m_taken();
        return m_isbr() && m_cond(dec_instr[11:9], flags);
    endfunction

    function automatic logic [15:0] m_target(input int k);
        int imm, t;
        if (dec_instr[15:12] == 4'hD) return rs_data & 16'hFFFE;
        imm = int'(dec_instr[8:0]);
        if (k == 0 && imm >= 256) imm = imm - 512;
        t = int'(dec_pc) + 2 + 2 * imm;
        return t[15:0];
    endfunction

    function automatic bit m_flush();
        return !m_halt && !stall && dec_valid && (dec_instr[15:12] == 4'hF || m_taken());
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic m_tick();
        bit hlt, tk, isb;
        logic [15:0] t0, t1;
        if (!m_halt && !stall) begin
            hlt = dec_valid && dec_instr[15:12] == 4'hF;
            tk  = m_taken();
            isb = m_isbr();
            t0  = m_target(0);
            t1  = m_target(1);
            if (hlt) begin
                m_pc[0] = dec_pc; m_pc[1] = dec_pc; m_halt = 1'b1;
            end else if (tk) begin
                m_pc[0] = t0; m_pc[1] = t1;
            end else begin
                m_pc[0] = m_pc[0] + 16'd2; m_pc[1] = m_pc[1] + 16'd2;
            end
            if (isb) m_br++;
            if (tk) m_tk++;
        end
    endtask

    task automatic m_reset();
        m_pc[0] = 16'h0100; m_pc[1] = 16'h0100; m_halt = 1'b0; m_br = 0; m_tk = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input vec_t tv);
        dec_valid = tv.v; dec_instr = tv.instr; dec_pc = tv.dpc;
        flags = tv.fl; rs_data = tv.rs; stall = tv.st;
    endtask

    // Entered and left at posedge+1
    task automatic run_cycle(input bit use_tab, input vec_t tv);
        drive(tv);
        #2;
        chk("flush", {31'd0, flush0}, {31'd0, use_tab ? tv.ef : m_flush()});
        chk("flush_sat", {31'd0, flush1}, {31'd0, m_flush()});
        @(posedge clk);
        m_tick();
        #1;
        chk("pc", {16'd0, pc0}, {16'd0, use_tab ? tv.epc : m_pc[0]});
        chk("halted", {31'd0, halted0}, {31'd0, use_tab ? tv.eh : m_halt});
        chk("br_cnt", {16'd0, br0}, use_tab ? {16'd0, tv.ebr} : 32'(sat(m_br, 65535)));
        chk("taken_cnt", {16'd0, tk0}, use_tab ? {16'd0, tv.etk} : 32'(sat(m_tk, 65535)));
        chk("pc_sat", {16'd0, pc1}, {16'd0, m_pc[1]});
        chk("halted_sat", {31'd0, halted1}, {31'd0, m_halt});
        chk("br_cnt_sat", {30'd0, br1}, 32'(sat(m_br, 3)));
        chk("taken_cnt_sat", {30'd0, tk1}, 32'(sat(m_tk, 3)));
    endtask

    // Reset asserted away from the clock edge; checks the asynchronous effect
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_pc", {16'd0, pc0}, 32'h0100);
        chk("rst_pc_sat", {16'd0, pc1}, 32'h0100);
        chk("rst_halted", {30'd0, halted1, halted0}, 32'd0);
        chk("rst_flush", {30'd0, flush1, flush0}, 32'd0);
        chk("rst_cnt", {br0, tk0}, 32'd0);
        chk("rst_cnt_sat", {28'd0, br1, tk1}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input logic [15:0] instr, input logic [15:0] dpc,
                                input logic [2:0] fl, input logic [15:0] rs, input logic st,
                                input logic ef, input logic [15:0] epc, input logic eh,
                                input logic [15:0] ebr, input logic [15:0] etk);
        vec_t r;
        r.v = v; r.instr = instr; r.dpc = dpc; r.fl = fl; r.rs = rs; r.st = st;
        r.ef = ef; r.epc = epc; r.eh = eh; r.ebr = ebr; r.etk = etk;
        return r;
    endfunction

    vec_t tab [14];
    vec_t rv;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; dec_valid = 1'b0; dec_instr = 16'h0000;
        dec_pc = 16'h0000; flags = 3'b000; rs_data = 16'h0000;
        m_reset();

        //          v     instr     dpc       fl      rs        st    ef    epc       eh    br     tk
        tab[0]  = mk(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0102, 1'b0, 16'd0, 16'd0);
        tab[1]  = mk(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0104, 1'b0, 16'd0, 16'd0);
        tab[2]  = mk(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0106, 1'b0, 16'd0, 16'd0);
        tab[3]  = mk(1'b1, 16'hC3FE, 16'h0010, 3'b001, 16'h0000, 1'b0, 1'b1, 16'h000E, 1'b0, 16'd1, 16'd1);
        tab[4]  = mk(1'b1, 16'hC3FE, 16'h0010, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 16'd2, 16'd1);
        tab[5]  = mk(1'b1, 16'hDE00, 16'h0020, 3'b000, 16'h4321, 1'b0, 1'b1, 16'h4320, 1'b0, 16'd3, 16'd2);
        tab[6]  = mk(1'b1, 16'hCE03, 16'hFFFC, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'd4, 16'd3);
        tab[7]  = mk(1'b1, 16'hCE10, 16'h0200, 3'b000, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b0, 16'd4, 16'd3);
        tab[8]  = mk(1'b1, 16'hCE10, 16'h0200, 3'b000, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b0, 16'd4, 16'd3);
        tab[9]  = mk(1'b1, 16'hCE10, 16'h0200, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0222, 1'b0, 16'd5, 16'd4);
        tab[10] = mk(1'b1, 16'hF000, 16'h0040, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b1, 16'd5, 16'd4);
        tab[11] = mk(1'b1, 16'hCE10, 16'h0200, 3'b111, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 16'd5, 16'd4);
        tab[12] = mk(1'b1, 16'hDE00, 16'h0200, 3'b111, 16'h8888, 1'b1, 1'b0, 16'h0040, 1'b1, 16'd5, 16'd4);
        tab[13] = mk(1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 16'd5, 16'd4);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) run_cycle(1'b1, tab[i]);

        // Reset while halted and with a taken branch in decode
        drive(mk(1'b1, 16'hDE00, 16'h0000, 3'b000, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0, 16'd0));
        do_reset();

        // Five taken branches: 2-bit counters saturate at 3
        for (int i = 0; i < 5; i++)
            run_cycle(1'b0, mk(1'b1, 16'hDE00, 16'h0000, 3'b000, 16'h1000, 1'b0,
                               1'b0, 16'h0, 1'b0, 16'd0, 16'd0));
        chk("sat_br_cnt", {30'd0, br1}, 32'd3);
        chk("sat_taken_cnt", {30'd0, tk1}, 32'd3);
        chk("wide_br_cnt", {16'd0, br0}, 32'd5);

        // Reset in the middle of a stalled branch
        drive(mk(1'b1, 16'hCE10, 16'h0200, 3'b000, 16'h0000, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0, 16'd0));
        do_reset();

        for (int i = 0; i < 600; i++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 15);
            if (r <= 5)       op = 4'hC;
            else if (r <= 9)  op = 4'hD;
            else if (r == 10) op = 4'hF;
            else              op = 4'($urandom_range(0, 11));
            rv = mk(($urandom_range(0, 4) != 0), {op, 12'($urandom)}, 16'($urandom),
                    3'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                    1'b0, 16'h0, 1'b0, 16'd0, 16'd0);
            if ($urandom_range(0, 24) == 0) begin
                drive(rv);
                do_reset();
            end else begin
                run_cycle(1'b0, rv);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
